// File: rtl/vga_rx_monitor.sv
// VGA receive-side timing monitor: locks onto hsync/vsync, recovers the
// pixel position, flags timing errors and captures one probed pixel.
module vga_rx_monitor #(
  parameter int H_VIS        = 640,
  parameter int H_SYNC_START = 656,
  parameter int H_SYNC_END   = 752,
  parameter int H_TOTAL      = 800,
  parameter int V_VIS        = 480,
  parameter int V_SYNC_START = 490,
  parameter int V_TOTAL      = 525
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        p_tick,
  input  logic        hsync,
  input  logic        vsync,
  input  logic [11:0] rgb,
  input  logic [9:0]  probe_x,
  input  logic [9:0]  probe_y,
  output logic [9:0]  x,
  output logic [9:0]  y,
  output logic        video_on,
  output logic        locked,
  output logic        h_err,
  output logic        v_err,
  output logic        frame_done,
  output logic [11:0] probe_rgb,
  output logic        probe_valid,
  output logic [7:0]  err_count
);

  localparam logic [9:0] HV  = 10'(H_VIS);
  localparam logic [9:0] HSS = 10'(H_SYNC_START);
  localparam logic [9:0] HSE = 10'(H_SYNC_END);
  localparam logic [9:0] HTL = 10'(H_TOTAL - 1);
  localparam logic [9:0] VV  = 10'(V_VIS);
  localparam logic [9:0] VSS = 10'(V_SYNC_START);
  localparam logic [9:0] VTL = 10'(V_TOTAL - 1);

  typedef enum logic [1:0] {
    SEARCH,
    HALIGN,
    VALIGN,
    LOCKED
  } state_t;

  state_t     state, state_n;
  logic [9:0] hcnt, vcnt;
  logic [9:0] hnext, vnext;
  logic [9:0] hc_n, vc_n;
  logic       hs_q, vs_q;
  logic       hwrap, vwrap;
  logic       hfall, vfall, at_hs;
  logic       h_bad, v_bad, h_e, v_e;
  logic       probe_hit;

  // hnext/vnext are the coordinates of the tick being sampled now
  assign hwrap = hcnt == HTL;
  assign vwrap = hwrap && (vcnt == VTL);
  assign hnext = hwrap ? '0 : hcnt + 10'd1;
  assign vnext = vwrap ? '0 : (hwrap ? vcnt + 10'd1 : vcnt);

  assign hfall = hs_q && !hsync;
  assign vfall = vs_q && !vsync;
  assign at_hs = hnext == HSS;

  assign h_bad = (hfall && !at_hs) || (hsync && at_hs) ||
                 (!hsync && (hnext == HSE));
  assign v_bad = (vfall && (vnext != VSS)) ||
                 (vsync && at_hs && (vnext == VSS));

  assign probe_hit = (hnext == probe_x) && (vnext == probe_y) &&
                     (probe_x < HV) && (probe_y < VV);

  always_comb begin
    state_n = state;
    hc_n    = hnext;
    vc_n    = vnext;
    h_e     = 1'b0;
    v_e     = 1'b0;
    unique case (state)
      SEARCH: begin
        if (hfall) begin
          hc_n    = HSS;
          state_n = HALIGN;
        end
      end
      HALIGN: begin
        if (hfall) begin
          hc_n = HSS;
          if (at_hs) state_n = VALIGN;
        end
      end
      VALIGN: begin
        if (hfall && !at_hs) begin
          hc_n    = HSS;
          state_n = HALIGN;
        end else if (vfall) begin
          vc_n    = VSS;
          state_n = LOCKED;
        end
      end
      LOCKED: begin
        h_e = h_bad;
        v_e = v_bad;
        if (h_bad || v_bad) state_n = SEARCH;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= SEARCH;
      hcnt        <= '0;
      vcnt        <= '0;
      hs_q        <= 1'b1;
      vs_q        <= 1'b1;
      x           <= '0;
      y           <= '0;
      video_on    <= 1'b0;
      locked      <= 1'b0;
      h_err       <= 1'b0;
      v_err       <= 1'b0;
      frame_done  <= 1'b0;
      probe_rgb   <= '0;
      probe_valid <= 1'b0;
      err_count   <= '0;
    end else begin
      h_err      <= 1'b0;
      v_err      <= 1'b0;
      frame_done <= 1'b0;
      if (p_tick) begin
        state      <= state_n;
        hs_q       <= hsync;
        vs_q       <= vsync;
        hcnt       <= hc_n;
        vcnt       <= vc_n;
        x          <= hc_n;
        y          <= vc_n;
        locked     <= state_n == LOCKED;
        video_on   <= (state_n == LOCKED) && (hc_n < HV) && (vc_n < VV);
        h_err      <= h_e;
        v_err      <= v_e;
        frame_done <= (state == LOCKED) && (state_n == LOCKED) && vwrap;
        if ((h_e || v_e) && (err_count != 8'hFF))
          err_count <= err_count + 8'd1;
        if (state_n != LOCKED) begin
          probe_valid <= 1'b0;
        end else if ((state == LOCKED) && probe_hit) begin
          probe_rgb   <= rgb;
          probe_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_vga_rx_monitor.sv
// Directed bench for vga_rx_monitor on a reduced 14x9 raster so that
// several hundred frames fit in a short run.
module tb_vga_rx_monitor;

  localparam int HV  = 8;
  localparam int HSS = 10;
  localparam int HSE = 12;
  localparam int HT  = 14;
  localparam int VV  = 4;
  localparam int VSS = 6;
  localparam int VT  = 9;

  logic        clk = 1'b0;
  logic        reset;
  logic        p_tick;
  logic        hsync;
  logic        vsync;
  logic [11:0] rgb;
  logic [9:0]  probe_x;
  logic [9:0]  probe_y;
  logic [9:0]  x;
  logic [9:0]  y;
  logic        video_on;
  logic        locked;
  logic        h_err;
  logic        v_err;
  logic        frame_done;
  logic [11:0] probe_rgb;
  logic        probe_valid;
  logic [7:0]  err_count;

  vga_rx_monitor #(
    .H_VIS(HV), .H_SYNC_START(HSS), .H_SYNC_END(HSE), .H_TOTAL(HT),
    .V_VIS(VV), .V_SYNC_START(VSS), .V_TOTAL(VT)
  ) dut (
    .clk(clk), .reset(reset), .p_tick(p_tick),
    .hsync(hsync), .vsync(vsync), .rgb(rgb),
    .probe_x(probe_x), .probe_y(probe_y),
    .x(x), .y(y), .video_on(video_on), .locked(locked),
    .h_err(h_err), .v_err(v_err), .frame_done(frame_done),
    .probe_rgb(probe_rgb), .probe_valid(probe_valid),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int passed = 0;

  // generator position and fault knobs
  int gx = 0, gy = 0, gf = 0;
  int line_len = HT;
  int frame_len = VT;
  bit stretch = 0;
  bit hs_hold = 0;
  bit gap = 1;
  bit track = 1;

  int herr_seen = 0, verr_seen = 0, fd_seen = 0, fd_bad = 0;
  int xy_bad = 0, hold_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic emit();
    int  lx, ly;
    logic hs, vs;
    lx = gx;
    ly = gy;
    hs = !(gx >= HSS && gx < (stretch ? HSE + 1 : HSE));
    if (hs_hold && gy == 1) hs = 1'b1;
    vs = !(gy >= VSS && gy < VSS + 2);
    hsync = hs;
    vsync = vs;
    rgb = (gx == int'(probe_x) && gy == int'(probe_y)) ? 12'hABC : 12'h000;
    p_tick = 1'b1;
    @(posedge clk);
    #1;
    p_tick = 1'b0;
    if (h_err) herr_seen++;
    if (v_err) verr_seen++;
    if (frame_done) begin
      fd_seen++;
      if (lx != 0 || ly != 0) fd_bad++;
    end
    if (track) begin
      if (locked) begin
        if (int'(x) != lx || int'(y) != ly ||
            video_on != (lx < HV && ly < VV)) xy_bad++;
      end else if (video_on) begin
        xy_bad++;
      end
    end
    gx++;
    if (gx >= line_len) begin
      gx = 0;
      line_len = HT;
      stretch = 0;
      gy++;
      if (gy >= frame_len) begin
        gy = 0;
        frame_len = VT;
        gf++;
      end
    end
  endtask

  task automatic idle();
    logic [9:0] sx, sy;
    logic sl;
    if (gap) begin
      sx = x;
      sy = y;
      sl = locked;
      @(posedge clk);
      #1;
      if (x != sx || y != sy || locked != sl ||
          h_err || v_err || frame_done) hold_bad++;
    end
  endtask

  task automatic pixel();
    emit();
    idle();
  endtask

  task automatic run_to(input int f, input int px, input int py,
                        input int budget);
    int n = 0;
    while (!(gf == f && gx == px && gy == py) && n < budget) begin
      pixel();
      n++;
    end
    check($sformatf("reach %0d.%0d.%0d", f, px, py),
          32'(gf == f && gx == px && gy == py), 32'd1);
  endtask

  task automatic clear_seen();
    herr_seen = 0;
    verr_seen = 0;
    fd_seen = 0;
    fd_bad = 0;
  endtask

  initial begin
    reset = 1'b0;
    p_tick = 1'b0;
    hsync = 1'b1;
    vsync = 1'b1;
    rgb = '0;
    probe_x = 10'd0;
    probe_y = 10'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_xy", {22'd0, x}, 32'd0);
    check("rst_y", {22'd0, y}, 32'd0);
    check("rst_flags", {26'd0, video_on, locked, h_err, v_err,
                        frame_done, probe_valid}, 32'd0);
    check("rst_rgb", {20'd0, probe_rgb}, 32'd0);
    check("rst_cnt", {24'd0, err_count}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    // acquisition from reset
    run_to(0, 0, 6, 200);
    check("prelock", {31'd0, locked}, 32'd0);
    emit();
    check("lock", {31'd0, locked}, 32'd1);
    check("lock_x", {22'd0, x}, 32'd0);
    check("lock_y", {22'd0, y}, 32'd6);
    check("lock_von", {31'd0, video_on}, 32'd0);
    idle();

    // probe outside the visible area, then inside
    probe_x = 10'd10;
    probe_y = 10'd2;
    run_to(2, 0, 0, 400);
    check("oob_valid", {31'd0, probe_valid}, 32'd0);
    check("oob_rgb", {20'd0, probe_rgb}, 32'd0);
    probe_x = 10'd5;
    probe_y = 10'd2;
    run_to(3, 0, 0, 200);
    check("probe_valid", {31'd0, probe_valid}, 32'd1);
    check("probe_rgb", {20'd0, probe_rgb}, 32'hABC);
    check("fd_count", 32'(fd_seen), 32'd2);
    check("fd_place", 32'(fd_bad), 32'd0);
    check("no_err", 32'(herr_seen + verr_seen), 32'd0);
    check("track1", 32'(xy_bad), 32'd0);

    // one line of HT-1 ticks
    track = 0;
    run_to(3, 0, 1, 50);
    line_len = HT - 1;
    run_to(3, 10, 2, 50);
    emit();
    check("short_herr", {31'd0, h_err}, 32'd1);
    check("short_verr", {31'd0, v_err}, 32'd0);
    check("short_lock", {31'd0, locked}, 32'd0);
    check("short_cnt", {24'd0, err_count}, 32'd1);
    check("short_pv", {31'd0, probe_valid}, 32'd0);
    idle();
    run_to(4, 0, 0, 200);
    check("relock1", {31'd0, locked}, 32'd1);
    check("relock1_cnt", {24'd0, err_count}, 32'd1);
    track = 1;

    // one frame of VT-1 lines
    track = 0;
    frame_len = VT - 1;
    run_to(5, 0, 6, 300);
    emit();
    check("vshort_verr", {31'd0, v_err}, 32'd1);
    check("vshort_herr", {31'd0, h_err}, 32'd0);
    check("vshort_lock", {31'd0, locked}, 32'd0);
    check("vshort_cnt", {24'd0, err_count}, 32'd2);
    idle();
    run_to(6, 0, 7, 300);
    check("relock2", {31'd0, locked}, 32'd1);
    track = 1;

    // hsync held low one tick too long
    run_to(7, 0, 1, 300);
    stretch = 1;
    run_to(7, 12, 1, 50);
    emit();
    check("long_herr", {31'd0, h_err}, 32'd1);
    check("long_x", {22'd0, x}, 32'd12);
    check("long_lock", {31'd0, locked}, 32'd0);
    check("long_cnt", {24'd0, err_count}, 32'd3);
    idle();
    run_to(8, 0, 0, 200);
    check("relock3", {31'd0, locked}, 32'd1);
    check("hold", 32'(hold_bad), 32'd0);

    // one forced error per frame up to and past saturation
    gap = 0;
    hs_hold = 1;
    clear_seen();
    run_to(259, 0, 0, 40000);
    check("cnt_254", {24'd0, err_count}, 32'd254);
    run_to(260, 0, 0, 200);
    check("cnt_255", {24'd0, err_count}, 32'd255);
    run_to(265, 0, 0, 1000);
    check("cnt_sat", {24'd0, err_count}, 32'd255);
    check("sat_herr", 32'(herr_seen), 32'd257);
    check("sat_fd", 32'(fd_seen), 32'd257);
    hs_hold = 0;

    // asynchronous reset mid-line while locked
    run_to(265, 3, 7, 200);
    check("pre_rst_lock", {31'd0, locked}, 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("arst_x", {22'd0, x}, 32'd0);
    check("arst_y", {22'd0, y}, 32'd0);
    check("arst_flags", {26'd0, video_on, locked, h_err, v_err,
                         frame_done, probe_valid}, 32'd0);
    check("arst_rgb", {20'd0, probe_rgb}, 32'd0);
    check("arst_cnt", {24'd0, err_count}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    gap = 1;
    pixel();
    check("post_rst_lock", {31'd0, locked}, 32'd0);
    run_to(266, 1, 6, 300);
    check("reacq_lock", {31'd0, locked}, 32'd1);
    check("reacq_y", {22'd0, y}, 32'd6);
    check("reacq_cnt", {24'd0, err_count}, 32'd0);
    check("track_all", 32'(xy_bad), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
